read_data_router: RTL and testbench
===================================

Name: read_data_router

Overview:
- Return-path counterpart of the read-address arbitration stage in the AXI interconnect.
- Records, in issue order, which master owns each read address accepted by the downstream slave.
- Steers R-channel beats (rvalid/rdata/rresp/rlast) from the slave back to the owning master and backpressures the slave with that master's rready.
- Ordering is strictly in-order (single-ID slave), so an order FIFO of master indices is sufficient.

Parameters:
- Masters_Num, 2, number of masters; the implementation supports exactly 2.
- Masters_ID_Size, $clog2(Masters_Num), width of the master index.
- Data_Width, 32, R data width in bits.
- Max_Outstanding, 4, depth of the order FIFO; must be a power of 2, ≥2.
- Timeout_Cycles, 1024, watchdog limit; used only with RD_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  reset, asynchronous, active-low.
- AR_Accepted  in  1  one-cycle pulse: AR handshake to slave completed this cycle.
- AR_Master  in  Masters_ID_Size  owner of the accepted AR; sampled with AR_Accepted.
- Order_Full  out  1  FIFO full; the arbiter must not grant a new AR while high.
- Outstanding_Count  out  $clog2(Max_Outstanding)+1  bursts issued, last beat not yet delivered.
- M_AXI_rvalid  in  1  slave R valid.
- M_AXI_rdata  in  Data_Width  slave R data.
- M_AXI_rresp  in  2  slave R response.
- M_AXI_rlast  in  1  slave R last.
- M_AXI_rready  out  1  ready to slave.
- S00_AXI_rvalid / S01_AXI_rvalid  out  1  per-master R valid.
- S00_AXI_rdata / S01_AXI_rdata  out  Data_Width  per-master R data.
- S00_AXI_rresp / S01_AXI_rresp  out  2  per-master R response.
- S00_AXI_rlast / S01_AXI_rlast  out  1  per-master R last.
- S00_AXI_rready / S01_AXI_rready  in  1  per-master ready.
- Orphan_Err  out  1  sticky: R beat arrived with no burst outstanding.
- Overflow_Err  out  1  sticky: AR_Accepted while Order_Full.

Behaviour:
- Reset (async assert, sync release): FIFO empty, wr/rd pointers 0, count 0, FSM=IDLE, both error flags 0. All outputs 0 during reset, including every rvalid and M_AXI_rready.
- Order FIFO:
  - Push AR_Master on AR_Accepted when not full.
  - Push while full: entry dropped, Overflow_Err←1, count unchanged.
  - Pointers wrap modulo Max_Outstanding.
  - Order_Full = (count==Max_Outstanding), combinational from the count register.
- Pop: on the beat handshake (M_AXI_rvalid & M_AXI_rready & M_AXI_rlast) in ROUTE.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - The entry pushed that cycle is routable no earlier than the next cycle.
- FSM states and transitions:
  - IDLE: FIFO empty; M_AXI_rready=0; all Sxx rvalid=0. → ROUTE when count becomes non-zero (one cycle after first push).
  - ROUTE: Head = FIFO head entry. S<Head>_AXI_rvalid = M_AXI_rvalid; the other master's rvalid=0. M_AXI_rready = S<Head>_AXI_rready.
    - rdata/rresp/rlast drive both masters combinationally from the slave (valid only where rvalid=1).
    - On the last-beat handshake: pop; → IDLE if the post-pop count is 0, else stay in ROUTE with the new head at zero bubble cycles.
  - DRAIN: entered from IDLE if M_AXI_rvalid=1 with count==0. Sets Orphan_Err←1, M_AXI_rready=1, no master rvalid. Beats discarded until the rlast handshake, → IDLE.
    - A push during DRAIN is still recorded.
    - After DRAIN, → ROUTE if count>0.
- Datapath: combinational, zero latency from the slave to the selected master. Routing state (head, FSM) is registered, so the route never changes mid-burst.
- Non-last beats never pop. The route holds across any number of beats and any rvalid/rready stall pattern.
- Master rvalid must not depend on that master's rready (AXI rule), which this mux satisfies.
- Error flags clear only on reset.
- Reset mid-burst: FIFO and FSM clear immediately; in-flight beats are lost (system-level reset assumption).

Optional Feature:
- Macro: RD_TIMEOUT_EN.
- When defined: adds output Timeout_Err (1 bit, sticky, reset 0) and a $clog2(Timeout_Cycles)+1-bit counter.
  - Counter increments each cycle with count>0 and no R handshake.
  - Counter clears on any R handshake or when count==0.
  - Reaching Timeout_Cycles sets Timeout_Err; the counter saturates. Routing is unaffected.
- When undefined: no counter, no Timeout_Err port.

Test Plan:
- Push M1, then a 4-beat burst with S01 rready=1 → beats only on S01, S00_rvalid=0 throughout; count 1→0 after the rlast cycle; FSM returns to IDLE.
- Push M0,M1,M0; three 2-beat bursts back-to-back → routing order S00,S01,S00 with no idle cycle between bursts; Outstanding_Count 3,2,1,0.
- Push 4 with Max_Outstanding=4 → Order_Full=1. A 5th AR_Accepted → Overflow_Err=1, count stays 4.
- Burst to M0 with S00_rready toggling 1,0,0,1 → M_AXI_rready mirrors it; no beat lost or duplicated; 2 stall cycles observed.
- R beat (rlast=1) with FIFO empty → Orphan_Err=1, M_AXI_rready=1, no Sxx rvalid asserted; a subsequent push+burst routes correctly.
- RD_TIMEOUT_EN, Timeout_Cycles=16: push M0, hold rvalid=0 for 16 cycles → Timeout_Err=1. Repeat with a beat at cycle 10 → no error.

Source files
------------

// File: rtl/read_data_router.sv
// read_data_router: return path of the AXI read interconnect.
// Remembers, in issue order, which master owns each read address the
// downstream slave accepted, and steers the slave's R beats back to that
// master while backpressuring the slave with the owner's rready.
// The slave returns bursts strictly in order, so a FIFO of master indices
// is all the bookkeeping needed.
// Optional build macro: RD_TIMEOUT_EN adds a stall watchdog and the
// sticky Timeout_Err output.
module read_data_router #(
  parameter int Masters_Num     = 2,
  parameter int Masters_ID_Size = $clog2(Masters_Num),
  parameter int Data_Width      = 32,
  parameter int Max_Outstanding = 4,
  parameter int Timeout_Cycles  = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  // Address-side bookkeeping from the AR arbiter
  input  logic                              AR_Accepted,
  input  logic [Masters_ID_Size-1:0]        AR_Master,
  output logic                              Order_Full,
  output logic [$clog2(Max_Outstanding):0]  Outstanding_Count,
  // Slave-side R channel
  input  logic                              M_AXI_rvalid,
  input  logic [Data_Width-1:0]             M_AXI_rdata,
  input  logic [1:0]                        M_AXI_rresp,
  input  logic                              M_AXI_rlast,
  output logic                              M_AXI_rready,
  // Master 0 R channel
  output logic                              S00_AXI_rvalid,
  output logic [Data_Width-1:0]             S00_AXI_rdata,
  output logic [1:0]                        S00_AXI_rresp,
  output logic                              S00_AXI_rlast,
  input  logic                              S00_AXI_rready,
  // Master 1 R channel
  output logic                              S01_AXI_rvalid,
  output logic [Data_Width-1:0]             S01_AXI_rdata,
  output logic [1:0]                        S01_AXI_rresp,
  output logic                              S01_AXI_rlast,
  input  logic                              S01_AXI_rready,
  // Sticky error flags
  output logic                              Orphan_Err,
  output logic                              Overflow_Err
`ifdef RD_TIMEOUT_EN
  ,
  output logic                              Timeout_Err
`endif
);

  localparam int PtrW = $clog2(Max_Outstanding);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Order FIFO storage and bookkeeping
  logic [Masters_ID_Size-1:0] order_mem [Max_Outstanding];
  logic [PtrW-1:0]            wr_ptr;
  logic [PtrW-1:0]            rd_ptr;
  logic [CntW-1:0]            count;
  logic [CntW-1:0]            count_nxt;

  logic                       push;
  logic                       push_drop;
  logic                       pop;
  logic                       drain_done;
  logic [Masters_ID_Size-1:0] head;
  logic [Masters_Num-1:0]     head_sel;

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------

  // Full is taken from the registered count so the arbiter sees a clean
  // signal; a push arriving while full is dropped even if a pop happens in
  // the same cycle.
  assign Order_Full        = (count == CntW'(Max_Outstanding));
  assign Outstanding_Count = count;
  assign push              = AR_Accepted & ~Order_Full;
  assign push_drop         = AR_Accepted & Order_Full;

  // Head entry selects the owner of the burst currently being returned.
  assign head     = order_mem[rd_ptr];
  assign head_sel = Masters_Num'(1) << head;

  // Only the last beat of a routed burst retires the FIFO entry.
  assign pop        = (state == ROUTE) & M_AXI_rvalid & M_AXI_rready & M_AXI_rlast;
  assign drain_done = (state == DRAIN) & M_AXI_rvalid & M_AXI_rlast;

  // Next occupancy: push and pop in the same cycle cancel out.
  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CntW'(1);
      2'b01:   count_nxt = count - CntW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap naturally because the
  // depth is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count_nxt;
    end
  end

  // Entry storage: captures the owner of each accepted AR.
  // NOTE: the storage array is deliberately not reset; an entry is only read
  // once count says it was written, so its power-up contents never matter.
  always_ff @(posedge ACLK) begin
    if (push) order_mem[wr_ptr] <= AR_Master;
  end

  // ---------------------------------------------------------------------
  // Routing FSM
  // ---------------------------------------------------------------------

  // State register: the route is registered so it never changes mid-burst.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: an entry pushed this cycle becomes routable on the
  // next one; a beat seen with nothing outstanding is an orphan to drain.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (count != '0)       state_nxt = ROUTE;
        else if (M_AXI_rvalid) state_nxt = DRAIN;
        else if (push)         state_nxt = ROUTE;
      end
      ROUTE: begin
        if (pop && (count_nxt == '0)) state_nxt = IDLE;
      end
      DRAIN: begin
        if (drain_done) state_nxt = (count_nxt != '0) ? ROUTE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output mux: zero-latency steering to the head master. A master's rvalid
  // depends only on the slave's rvalid and the registered route, never on
  // that master's own rready.
  always_comb begin
    M_AXI_rready   = 1'b0;
    S00_AXI_rvalid = 1'b0;
    S00_AXI_rdata  = '0;
    S00_AXI_rresp  = '0;
    S00_AXI_rlast  = 1'b0;
    S01_AXI_rvalid = 1'b0;
    S01_AXI_rdata  = '0;
    S01_AXI_rresp  = '0;
    S01_AXI_rlast  = 1'b0;
    unique case (state)
      ROUTE: begin
        S00_AXI_rvalid = head_sel[0] & M_AXI_rvalid;
        S01_AXI_rvalid = head_sel[1] & M_AXI_rvalid;
        M_AXI_rready   = (head_sel[0] & S00_AXI_rready) |
                         (head_sel[1] & S01_AXI_rready);
        // Payload fans out to both masters; only the rvalid qualifies it.
        S00_AXI_rdata  = M_AXI_rdata;
        S00_AXI_rresp  = M_AXI_rresp;
        S00_AXI_rlast  = M_AXI_rlast;
        S01_AXI_rdata  = M_AXI_rdata;
        S01_AXI_rresp  = M_AXI_rresp;
        S01_AXI_rlast  = M_AXI_rlast;
      end
      DRAIN: begin
        // Swallow orphan beats until the burst's last beat.
        M_AXI_rready = 1'b1;
      end
      default: begin
        M_AXI_rready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------

  // Errors latch until reset: orphan on entry to DRAIN, overflow on a
  // dropped push.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      Orphan_Err   <= 1'b0;
      Overflow_Err <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_nxt == DRAIN)) Orphan_Err <= 1'b1;
      if (push_drop)                               Overflow_Err <= 1'b1;
    end
  end

`ifdef RD_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // Stall watchdog
  // ---------------------------------------------------------------------
  localparam int ToW = $clog2(Timeout_Cycles) + 1;

  logic [ToW-1:0] to_cnt;
  logic           r_hs;

  assign r_hs = M_AXI_rvalid & M_AXI_rready;

  // Watchdog counter: counts cycles with work outstanding and no R
  // progress; saturates at the limit. Routing never looks at it.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      to_cnt      <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      if ((count == '0) || r_hs)             to_cnt <= '0;
      else if (to_cnt != ToW'(Timeout_Cycles)) to_cnt <= to_cnt + ToW'(1);
      if (to_cnt == ToW'(Timeout_Cycles))      Timeout_Err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_read_data_router.sv
// Directed testbench for read_data_router. Inputs change on the falling
// edge; outputs are sampled 1 ns later, away from the rising edge.
module tb_read_data_router;

  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          AR_Accepted = 1'b0;
  logic [0:0]    AR_Master = '0;
  logic          Order_Full;
  logic [2:0]    Outstanding_Count;
  logic          M_AXI_rvalid = 1'b0;
  logic [DW-1:0] M_AXI_rdata = '0;
  logic [1:0]    M_AXI_rresp = '0;
  logic          M_AXI_rlast = 1'b0;
  logic          M_AXI_rready;
  logic          S00_AXI_rvalid, S01_AXI_rvalid;
  logic [DW-1:0] S00_AXI_rdata, S01_AXI_rdata;
  logic [1:0]    S00_AXI_rresp, S01_AXI_rresp;
  logic          S00_AXI_rlast, S01_AXI_rlast;
  logic          S00_AXI_rready = 1'b0;
  logic          S01_AXI_rready = 1'b0;
  logic          Orphan_Err, Overflow_Err;
`ifdef RD_TIMEOUT_EN
  logic          Timeout_Err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  read_data_router #(
    .Masters_Num(2), .Masters_ID_Size(1), .Data_Width(DW),
    .Max_Outstanding(4), .Timeout_Cycles(16)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AR_Accepted(AR_Accepted), .AR_Master(AR_Master),
    .Order_Full(Order_Full), .Outstanding_Count(Outstanding_Count),
    .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rdata(M_AXI_rdata),
    .M_AXI_rresp(M_AXI_rresp), .M_AXI_rlast(M_AXI_rlast),
    .M_AXI_rready(M_AXI_rready),
    .S00_AXI_rvalid(S00_AXI_rvalid), .S00_AXI_rdata(S00_AXI_rdata),
    .S00_AXI_rresp(S00_AXI_rresp), .S00_AXI_rlast(S00_AXI_rlast),
    .S00_AXI_rready(S00_AXI_rready),
    .S01_AXI_rvalid(S01_AXI_rvalid), .S01_AXI_rdata(S01_AXI_rdata),
    .S01_AXI_rresp(S01_AXI_rresp), .S01_AXI_rlast(S01_AXI_rlast),
    .S01_AXI_rready(S01_AXI_rready),
    .Orphan_Err(Orphan_Err), .Overflow_Err(Overflow_Err)
`ifdef RD_TIMEOUT_EN
    , .Timeout_Err(Timeout_Err)
`endif
  );

  always #5 ACLK = ~ACLK;

  // {S00 rvalid, S01 rvalid, slave rready} observed together
  wire [2:0] vec = {S00_AXI_rvalid, S01_AXI_rvalid, M_AXI_rready};

  int bb_master [3] = '{0, 1, 0};

  task automatic quiet_inputs();
    AR_Accepted  = 1'b0;
    AR_Master    = '0;
    M_AXI_rvalid = 1'b0;
    M_AXI_rdata  = '0;
    M_AXI_rresp  = '0;
    M_AXI_rlast  = 1'b0;
  endtask

  task automatic test_reset();
    // Drive a live-looking slave beat during reset; nothing may leak out.
    M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'hDEAD_BEEF; M_AXI_rresp = 2'd2; M_AXI_rlast = 1'b1;
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    @(negedge ACLK); #1;
    n_cmp++; if (vec !== 3'b000) begin n_bad++; $display("FAIL reset_valid_ready: got %b want 000", vec); end
    n_cmp++; if (S00_AXI_rdata !== '0 || S01_AXI_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", S00_AXI_rdata, S01_AXI_rdata); end
    n_cmp++; if ({S00_AXI_rlast, S01_AXI_rlast, S00_AXI_rresp, S01_AXI_rresp} !== 6'b0) begin n_bad++; $display("FAIL reset_rlast_rresp: got %b want 0", {S00_AXI_rlast, S01_AXI_rlast, S00_AXI_rresp, S01_AXI_rresp}); end
    n_cmp++; if (Outstanding_Count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", Outstanding_Count); end
    n_cmp++; if ({Order_Full, Orphan_Err, Overflow_Err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {Order_Full, Orphan_Err, Overflow_Err}); end
    @(negedge ACLK);
    quiet_inputs();
    ARESETN = 1'b1;
    @(negedge ACLK); #1;
    n_cmp++; if ({vec, Orphan_Err} !== 4'b0000) begin n_bad++; $display("FAIL reset_release: got %b want 0000", {vec, Orphan_Err}); end
  endtask

  task automatic test_single_route();
    S00_AXI_rready = 1'b0; S01_AXI_rready = 1'b1;
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b1;
    #1;
    n_cmp++; if (Outstanding_Count !== 3'd0) begin n_bad++; $display("FAIL single_count_push: got %0d want 0", Outstanding_Count); end
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      AR_Accepted = 1'b0;
      M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'hA000_0000 + i; M_AXI_rresp = 2'(i); M_AXI_rlast = (i == 3);
      #1;
      n_cmp++; if (vec !== 3'b011) begin n_bad++; $display("FAIL single_route beat%0d: got %b want 011", i, vec); end
      n_cmp++; if (S01_AXI_rdata !== 32'hA000_0000 + i) begin n_bad++; $display("FAIL single_rdata beat%0d: got %h want %h", i, S01_AXI_rdata, 32'hA000_0000 + i); end
      n_cmp++; if ({S01_AXI_rresp, S01_AXI_rlast} !== {2'(i), (i == 3)}) begin n_bad++; $display("FAIL single_resp_last beat%0d: got %b want %b", i, {S01_AXI_rresp, S01_AXI_rlast}, {2'(i), (i == 3)}); end
      n_cmp++; if (Outstanding_Count !== 3'd1) begin n_bad++; $display("FAIL single_count beat%0d: got %0d want 1", i, Outstanding_Count); end
    end
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if (Outstanding_Count !== 3'd0) begin n_bad++; $display("FAIL single_count_after: got %0d want 0", Outstanding_Count); end
    // S01 still ready: a non-zero rready would mean the FSM stayed in ROUTE
    n_cmp++; if (vec !== 3'b000) begin n_bad++; $display("FAIL single_idle: got %b want 000", vec); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_vec;
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      AR_Accepted = 1'b1; AR_Master = 1'(bb_master[k]);
      #1;
      n_cmp++; if (Outstanding_Count !== 3'(k)) begin n_bad++; $display("FAIL b2b_push_count push%0d: got %0d want %0d", k, Outstanding_Count, k); end
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge ACLK);
      AR_Accepted = 1'b0;
      M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'h100 + j; M_AXI_rlast = j[0];
      #1;
      exp_vec = (bb_master[j / 2] == 0) ? 3'b101 : 3'b011;
      n_cmp++; if (vec !== exp_vec) begin n_bad++; $display("FAIL b2b_route beat%0d: got %b want %b", j, vec, exp_vec); end
      n_cmp++; if (Outstanding_Count !== 3'(3 - j / 2)) begin n_bad++; $display("FAIL b2b_count beat%0d: got %0d want %0d", j, Outstanding_Count, 3 - j / 2); end
      n_cmp++; if (((bb_master[j / 2] == 0) ? S00_AXI_rdata : S01_AXI_rdata) !== 32'h100 + j) begin n_bad++; $display("FAIL b2b_rdata beat%0d: got %h/%h want %h", j, S00_AXI_rdata, S01_AXI_rdata, 32'h100 + j); end
    end
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if ({Outstanding_Count, vec} !== 6'b000_000) begin n_bad++; $display("FAIL b2b_end: got count %0d vec %b want 0 000", Outstanding_Count, vec); end
  endtask

  task automatic test_overflow();
    logic [2:0] exp_vec;
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      AR_Accepted = 1'b1; AR_Master = 1'(k % 2);
      #1;
      n_cmp++; if (Order_Full !== 1'b0) begin n_bad++; $display("FAIL ovf_not_full push%0d: got %b want 0", k, Order_Full); end
    end
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b0;
    #1;
    n_cmp++; if ({Order_Full, Outstanding_Count, Overflow_Err} !== {1'b1, 3'd4, 1'b0}) begin n_bad++; $display("FAIL ovf_full: got full %b count %0d err %b want 1 4 0", Order_Full, Outstanding_Count, Overflow_Err); end
    @(negedge ACLK);
    AR_Accepted = 1'b0;
    #1;
    n_cmp++; if ({Order_Full, Outstanding_Count, Overflow_Err} !== {1'b1, 3'd4, 1'b1}) begin n_bad++; $display("FAIL ovf_dropped: got full %b count %0d err %b want 1 4 1", Order_Full, Outstanding_Count, Overflow_Err); end
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1; M_AXI_rdata = 32'h200 + i;
      #1;
      exp_vec = (i % 2 == 0) ? 3'b101 : 3'b011;
      n_cmp++; if (vec !== exp_vec) begin n_bad++; $display("FAIL ovf_route burst%0d: got %b want %b", i, vec, exp_vec); end
      n_cmp++; if (Outstanding_Count !== 3'(4 - i)) begin n_bad++; $display("FAIL ovf_count burst%0d: got %0d want %0d", i, Outstanding_Count, 4 - i); end
    end
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if ({Order_Full, Outstanding_Count, vec} !== 7'b0) begin n_bad++; $display("FAIL ovf_end: got full %b count %0d vec %b want 0 0 000", Order_Full, Outstanding_Count, vec); end
  endtask

  task automatic test_stall();
    int  beat = 0;
    int  cyc = 0;
    int  stalls = 0;
    logic rdy;
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b0;
    while (beat < 4 && cyc < 20) begin
      @(negedge ACLK);
      AR_Accepted = 1'b0;
      rdy = !(cyc == 1 || cyc == 2);
      S00_AXI_rready = rdy;
      M_AXI_rvalid = 1'b1; M_AXI_rdata = 32'hC0 + beat; M_AXI_rlast = (beat == 3);
      #1;
      n_cmp++; if (M_AXI_rready !== rdy) begin n_bad++; $display("FAIL stall_mirror cyc%0d: got %b want %b", cyc, M_AXI_rready, rdy); end
      n_cmp++; if ({S00_AXI_rvalid, S01_AXI_rvalid} !== 2'b10) begin n_bad++; $display("FAIL stall_valid cyc%0d: got %b want 10", cyc, {S00_AXI_rvalid, S01_AXI_rvalid}); end
      n_cmp++; if (S00_AXI_rdata !== 32'hC0 + beat) begin n_bad++; $display("FAIL stall_rdata cyc%0d: got %h want %h", cyc, S00_AXI_rdata, 32'hC0 + beat); end
      n_cmp++; if (Outstanding_Count !== 3'd1) begin n_bad++; $display("FAIL stall_count cyc%0d: got %0d want 1", cyc, Outstanding_Count); end
      if (M_AXI_rvalid && M_AXI_rready) beat++;
      else stalls++;
      cyc++;
    end
    n_cmp++; if (cyc !== 6 || beat !== 4) begin n_bad++; $display("FAIL stall_cycles: got %0d cycles %0d beats want 6 4", cyc, beat); end
    n_cmp++; if (stalls !== 2) begin n_bad++; $display("FAIL stall_count_stalls: got %0d want 2", stalls); end
    @(negedge ACLK);
    quiet_inputs();
    S00_AXI_rready = 1'b1;
    #1;
    n_cmp++; if ({Outstanding_Count, vec} !== 6'b0) begin n_bad++; $display("FAIL stall_end: got count %0d vec %b want 0 000", Outstanding_Count, vec); end
  endtask

  task automatic test_orphan();
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    @(negedge ACLK);
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1; M_AXI_rdata = 32'h0BAD;
    #1;
    n_cmp++; if ({vec, Orphan_Err} !== 4'b0000) begin n_bad++; $display("FAIL orphan_first: got %b want 0000", {vec, Orphan_Err}); end
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b1;
    #1;
    n_cmp++; if ({vec, Orphan_Err} !== 4'b0011) begin n_bad++; $display("FAIL orphan_drain: got %b want 0011", {vec, Orphan_Err}); end
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if ({Outstanding_Count, vec} !== {3'd1, 3'b001}) begin n_bad++; $display("FAIL orphan_push_kept: got count %0d vec %b want 1 001", Outstanding_Count, vec); end
    @(negedge ACLK);
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1; M_AXI_rdata = 32'h5EED;
    #1;
    n_cmp++; if ({vec, S01_AXI_rdata} !== {3'b011, 32'h5EED}) begin n_bad++; $display("FAIL orphan_reroute: got %b %h want 011 00005eed", vec, S01_AXI_rdata); end
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if ({Outstanding_Count, vec, Orphan_Err} !== {3'd0, 3'b000, 1'b1}) begin n_bad++; $display("FAIL orphan_end: got count %0d vec %b err %b want 0 000 1", Outstanding_Count, vec, Orphan_Err); end
  endtask

  task automatic test_error_reset();
    @(negedge ACLK); #1;
    n_cmp++; if ({Orphan_Err, Overflow_Err} !== 2'b11) begin n_bad++; $display("FAIL err_sticky: got %b want 11", {Orphan_Err, Overflow_Err}); end
    @(negedge ACLK);
    ARESETN = 1'b0;
    #1;
    n_cmp++; if ({Orphan_Err, Overflow_Err} !== 2'b00) begin n_bad++; $display("FAIL err_cleared: got %b want 00", {Orphan_Err, Overflow_Err}); end
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

`ifdef RD_TIMEOUT_EN
  task automatic test_timeout();
    S00_AXI_rready = 1'b1; S01_AXI_rready = 1'b1;
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b0;
    @(negedge ACLK);
    AR_Accepted = 1'b0;
    repeat (13) @(negedge ACLK);
    #1;
    n_cmp++; if (Timeout_Err !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", Timeout_Err); end
    repeat (6) @(negedge ACLK);
    #1;
    n_cmp++; if (Timeout_Err !== 1'b1) begin n_bad++; $display("FAIL timeout_set: got %b want 1", Timeout_Err); end
    @(negedge ACLK);
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1;
    #1;
    n_cmp++; if (vec !== 3'b101) begin n_bad++; $display("FAIL timeout_route: got %b want 101", vec); end
    @(negedge ACLK);
    quiet_inputs();
    ARESETN = 1'b0;
    #1;
    n_cmp++; if (Timeout_Err !== 1'b0) begin n_bad++; $display("FAIL timeout_reset: got %b want 0", Timeout_Err); end
    @(negedge ACLK);
    ARESETN = 1'b1;
    // Same stall, but a non-last beat at cycle 10 restarts the watchdog.
    @(negedge ACLK);
    AR_Accepted = 1'b1; AR_Master = 1'b0;
    @(negedge ACLK);
    AR_Accepted = 1'b0;
    repeat (9) @(negedge ACLK);
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b0;
    @(negedge ACLK);
    M_AXI_rvalid = 1'b0;
    repeat (9) @(negedge ACLK);
    #1;
    n_cmp++; if (Timeout_Err !== 1'b0) begin n_bad++; $display("FAIL timeout_beat_clears: got %b want 0", Timeout_Err); end
    @(negedge ACLK);
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1;
    @(negedge ACLK);
    quiet_inputs();
    #1;
    n_cmp++; if ({Outstanding_Count, Timeout_Err} !== 4'b0) begin n_bad++; $display("FAIL timeout_end: got count %0d err %b want 0 0", Outstanding_Count, Timeout_Err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_route();
    test_back_to_back();
    test_overflow();
    test_stall();
    test_orphan();
    test_error_reset();
`ifdef RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "time limit");
  end

endmodule
